// File: rtl/harry_porter_relay_cpu_pkg.sv
// Shared types and opcode constants for the Harry Porter relay computer model.
// Build option HPC_STORE_EN (see top) changes how STORE decodes; nothing here depends on it.
package hpc_pkg;

   localparam int STATE_W = 96;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_JADDR  = 2'd2,
      ST_HALTED = 2'd3
   } hpc_state_e;

   typedef enum logic [2:0] {
      REG_A  = 3'd0,
      REG_B  = 3'd1,
      REG_C  = 3'd2,
      REG_D  = 3'd3,
      REG_M1 = 3'd4,
      REG_M2 = 3'd5,
      REG_X  = 3'd6,
      REG_Y  = 3'd7
   } hpc_reg_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_INC = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_NOT = 3'd5,
      ALU_ROL = 3'd6,
      ALU_CLR = 3'd7
   } hpc_alu_e;

   typedef struct packed {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [7:0]  c;
      logic [7:0]  d;
      logic [7:0]  m1;
      logic [7:0]  m2;
      logic [7:0]  x;
      logic [7:0]  y;
      logic [15:0] pc;
      logic [7:0]  ir;
      logic        cy;
      logic        z;
      logic        s;
      logic        halt;
      logic [3:0]  pad;
   } hpc_state_word_t;

   localparam logic [7:0] MASK_MOV8  = 8'hC0;
   localparam logic [7:0] OP_MOV8    = 8'h00;
   localparam logic [7:0] MASK_SETAB = 8'hC0;
   localparam logic [7:0] OP_SETAB   = 8'h40;
   localparam logic [7:0] MASK_ALU   = 8'hF0;
   localparam logic [7:0] OP_ALU     = 8'h80;
   localparam logic [7:0] MASK_LOAD  = 8'hFC;
   localparam logic [7:0] OP_LOAD    = 8'h90;
   localparam logic [7:0] MASK_STORE = 8'hFC;
   localparam logic [7:0] OP_STORE   = 8'h98;
   localparam logic [7:0] OP_HALT    = 8'hAE;
   localparam logic [7:0] MASK_GOTO  = 8'hC3;
   localparam logic [7:0] OP_GOTO    = 8'hC0;

   function automatic logic op_match(input logic [7:0] ir, input logic [7:0] mask,
                                     input logic [7:0] op);
      return (ir & mask) == op;
   endfunction

endpackage

// File: rtl/harry_porter_relay_cpu_if.sv
// Program-load request and state-export bus between the transaction layer and the CPU model.
interface harry_porter_relay_cpu_if #(
   parameter int OUT_WIDTH  = 96,
   parameter int INIT_BYTES = 15
);
   logic                       loadMem;
   logic [INIT_BYTES-1:0][7:0] initial_memory;
   logic [OUT_WIDTH-1:0]       returned_from_comp;
   logic                       loadMemComplete;

   modport master (
      output loadMem,
      output initial_memory,
      input  returned_from_comp,
      input  loadMemComplete
   );

   modport slave (
      input  loadMem,
      input  initial_memory,
      output returned_from_comp,
      output loadMemComplete
   );
endinterface

// File: rtl/harry_porter_relay_cpu_alu.sv
// Combinational ALU: operates on B and C, produces result plus carry, zero and sign flags.
module hpc_alu
   import hpc_pkg::*;
(
   input  logic [7:0] b,
   input  logic [7:0] c,
   input  hpc_alu_e   f,
   output logic [7:0] result,
   output logic       cy,
   output logic       z,
   output logic       s
);
   logic [8:0] sum_s;
   logic [8:0] inc_s;

   assign sum_s = {1'b0, b} + {1'b0, c};
   assign inc_s = {1'b0, b} + 9'd1;

   // Function select; carry is only meaningful for add, increment and rotate.
   always_comb begin
      result = 8'h00;
      cy     = 1'b0;
      case (f)
         ALU_ADD: begin result = sum_s[7:0]; cy = sum_s[8]; end
         ALU_INC: begin result = inc_s[7:0]; cy = inc_s[8]; end
         ALU_AND: result = b & c;
         ALU_OR:  result = b | c;
         ALU_XOR: result = b ^ c;
         ALU_NOT: result = ~b;
         ALU_ROL: begin result = {b[6:0], b[7]}; cy = b[7]; end
         ALU_CLR: result = 8'h00;
         default: result = 8'h00;
      endcase
      z = (result == 8'h00);
      s = result[7];
   end
endmodule

// File: rtl/harry_porter_relay_cpu.sv
// Behavioural Harry Porter relay computer: loads a program image, runs one instruction per clock.
// Define HPC_STORE_EN to let STORE write RAM; otherwise STORE decodes as a NOP.
module harry_porter_relay_cpu
   import hpc_pkg::*;
#(
   parameter int OUT_WIDTH  = 96,
   parameter int INIT_BYTES = 15
)
(
   input  logic                      clock,
   input  logic                      reset,
   harry_porter_relay_cpu_if.slave   bus
);
   hpc_state_e      state_r, next_state_s;
   logic [7:0]      ram_r [256];
   logic [7:0]      regs_r [8];
   logic [15:0]     pc_r, pc_next_s;
   logic [7:0]      ir_r, ir_s, pc_inc_s;
   logic            cy_r, z_r, s_r, halt_r, loaded_r;
   logic            reg_we_s, flags_we_s, ir_we_s, halt_set_s, load_img_s, take_s;
   logic [2:0]      reg_dst_s;
   logic [7:0]      reg_wdata_s;
   hpc_alu_e        alu_f_s;
   logic [7:0]      alu_result_s;
   logic            alu_cy_s, alu_z_s, alu_s_s;
   hpc_state_word_t word_s;
`ifdef HPC_STORE_EN
   logic            ram_we_s;
`endif

   assign ir_s     = ram_r[pc_r[7:0]];
   assign pc_inc_s = pc_r[7:0] + 8'd1;
   assign alu_f_s  = hpc_alu_e'(ir_s[2:0]);

   hpc_alu u_alu (
      .b      (regs_r[REG_B]),
      .c      (regs_r[REG_C]),
      .f      (alu_f_s),
      .result (alu_result_s),
      .cy     (alu_cy_s),
      .z      (alu_z_s),
      .s      (alu_s_s)
   );

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) state_r <= ST_IDLE;
      else       state_r <= next_state_s;
   end

   // Decode and next-state: one instruction is fetched and executed per FETCH cycle.
   always_comb begin
      next_state_s = state_r;
      pc_next_s    = pc_r;
      reg_we_s     = 1'b0;
      reg_dst_s    = 3'd0;
      reg_wdata_s  = 8'h00;
      flags_we_s   = 1'b0;
      ir_we_s      = 1'b0;
      halt_set_s   = 1'b0;
      load_img_s   = 1'b0;
      take_s       = 1'b0;
`ifdef HPC_STORE_EN
      ram_we_s     = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (bus.loadMem) begin
               load_img_s   = 1'b1;
               next_state_s = ST_FETCH;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            ir_we_s      = 1'b1;
            pc_next_s    = {8'h00, pc_inc_s};
            next_state_s = ST_FETCH;
            if (op_match(ir_s, MASK_MOV8, OP_MOV8)) begin
               reg_we_s    = 1'b1;
               reg_dst_s   = ir_s[5:3];
               reg_wdata_s = (ir_s[5:3] == ir_s[2:0]) ? 8'h00 : regs_r[ir_s[2:0]];
            end else if (op_match(ir_s, MASK_SETAB, OP_SETAB)) begin
               reg_we_s    = 1'b1;
               reg_dst_s   = ir_s[5] ? REG_B : REG_A;
               reg_wdata_s = {{3{ir_s[4]}}, ir_s[4:0]};
            end else if (op_match(ir_s, MASK_ALU, OP_ALU)) begin
               reg_we_s    = 1'b1;
               reg_dst_s   = ir_s[3] ? REG_D : REG_A;
               reg_wdata_s = alu_result_s;
               flags_we_s  = 1'b1;
            end else if (op_match(ir_s, MASK_LOAD, OP_LOAD)) begin
               reg_we_s    = 1'b1;
               reg_dst_s   = {1'b0, ir_s[1:0]};
               reg_wdata_s = ram_r[regs_r[REG_M2]];
`ifdef HPC_STORE_EN
            end else if (op_match(ir_s, MASK_STORE, OP_STORE)) begin
               ram_we_s    = 1'b1;
`endif
            end else if (ir_s == OP_HALT) begin
               halt_set_s   = 1'b1;
               next_state_s = ST_HALTED;
            end else if (op_match(ir_s, MASK_GOTO, OP_GOTO)) begin
               next_state_s = ST_JADDR;
            end else begin
               next_state_s = ST_FETCH;
            end
         end
         ST_JADDR: begin
            // IR still holds the GOTO byte: bits 5..2 are u, s, c, z.
            take_s       = ir_r[5] | (ir_r[4] & s_r) | (ir_r[3] & cy_r) | (ir_r[2] & z_r);
            pc_next_s    = take_s ? {8'h00, ir_s} : {8'h00, pc_inc_s};
            next_state_s = ST_FETCH;
         end
         ST_HALTED: next_state_s = ST_HALTED;
         default:   next_state_s = ST_IDLE;
      endcase
   end

   // Architectural registers, flags, PC and IR.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) regs_r[i] <= 8'h00;
         pc_r     <= 16'h0000;
         ir_r     <= 8'h00;
         cy_r     <= 1'b0;
         z_r      <= 1'b0;
         s_r      <= 1'b0;
         halt_r   <= 1'b0;
         loaded_r <= 1'b0;
      end else begin
         pc_r <= pc_next_s;
         if (ir_we_s)    ir_r <= ir_s;
         if (reg_we_s)   regs_r[reg_dst_s] <= reg_wdata_s;
         if (flags_we_s) begin
            cy_r <= alu_cy_s;
            z_r  <= alu_z_s;
            s_r  <= alu_s_s;
         end
         if (halt_set_s) halt_r   <= 1'b1;
         if (load_img_s) loaded_r <= 1'b1;
      end
   end

   // Program RAM: cleared on reset, image load zero-fills beyond the image.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < 256; k++) ram_r[k] <= 8'h00;
      end else if (load_img_s) begin
         for (int k = 0; k < 256; k++) ram_r[k] <= 8'h00;
         for (int k = 0; k < INIT_BYTES; k++) ram_r[k] <= bus.initial_memory[k];
`ifdef HPC_STORE_EN
      end else if (ram_we_s) begin
         ram_r[regs_r[REG_M2]] <= regs_r[{1'b0, ir_s[1:0]}];
`endif
      end
   end

   // Pack the exported state word from registered state.
   always_comb begin
      word_s      = '0;
      word_s.a    = regs_r[REG_A];
      word_s.b    = regs_r[REG_B];
      word_s.c    = regs_r[REG_C];
      word_s.d    = regs_r[REG_D];
      word_s.m1   = regs_r[REG_M1];
      word_s.m2   = regs_r[REG_M2];
      word_s.x    = regs_r[REG_X];
      word_s.y    = regs_r[REG_Y];
      word_s.pc   = pc_r;
      word_s.ir   = ir_r;
      word_s.cy   = cy_r;
      word_s.z    = z_r;
      word_s.s    = s_r;
      word_s.halt = halt_r;
      word_s.pad  = 4'b0000;
   end

   assign bus.returned_from_comp = OUT_WIDTH'(word_s);
   assign bus.loadMemComplete    = loaded_r;
endmodule

// File: tb/tb_harry_porter_relay_cpu.sv
// Directed bench: table of program images with hand-computed final state words, plus
// hand sequences for idle hold, reset mid-run and PC wrap-around.
module tb_harry_porter_relay_cpu;
   logic clock = 1'b0;
   logic reset;
   int   checks;
   int   errors;

   always #5 clock = ~clock;

   harry_porter_relay_cpu_if #(.OUT_WIDTH(96), .INIT_BYTES(15)) bus ();

   harry_porter_relay_cpu #(.OUT_WIDTH(96), .INIT_BYTES(15)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [119:0] img;
      logic [95:0]  exp;
      string        name;
   } vec_t;

   vec_t vecs [7];

   localparam logic [7:0] D_AFTER_LOAD =
`ifdef HPC_STORE_EN
      8'h07;
`else
      8'h00;
`endif

   function automatic logic [95:0] mkw(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d,
                                       input logic [7:0] m1, input logic [7:0] m2,
                                       input logic [7:0] x, input logic [7:0] y,
                                       input logic [15:0] pc, input logic [7:0] ir,
                                       input logic [3:0] fl);
      return {a, b, c, d, m1, m2, x, y, pc, ir, fl, 4'h0};
   endfunction

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic do_reset;
      reset       = 1'b1;
      bus.loadMem = 1'b0;
      repeat (2) tick;
      reset = 1'b0;
   endtask

   task automatic load(input logic [119:0] img);
      bus.initial_memory = img;
      bus.loadMem        = 1'b1;
      tick;
      bus.loadMem = 1'b0;
   endtask

   task automatic run_to_halt(input string name);
      for (int i = 0; i < 300; i++) begin
         if (bus.returned_from_comp[4]) break;
         tick;
      end
      chk({name, "_halt_reached"}, {95'b0, bus.returned_from_comp[4]}, {95'b0, 1'b1});
   endtask

   initial begin
      checks             = 0;
      errors             = 0;
      reset              = 1'b1;
      bus.loadMem        = 1'b0;
      bus.initial_memory = '0;

      vecs[0] = '{120'hAE_80_11_63_45,
                  mkw(8'h06, 8'h03, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0005, 8'hAE, 4'h1), "add_prog"};
      vecs[1] = '{120'hAE_5F,
                  mkw(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0002, 8'hAE, 4'h1), "seta_neg"};
      vecs[2] = '{120'hAE_41_03_E0,
                  mkw(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0004, 8'hAE, 4'h1), "goto_uncond"};
      vecs[3] = '{120'hAE_93_98_47_29_6A,
                  mkw(8'h07, 8'h0A, 8'h00, D_AFTER_LOAD, 8'h00, 8'h0A, 8'h00, 8'h00, 16'h0006, 8'hAE, 4'h1), "store_load"};
      vecs[4] = '{120'hAE_41_05_C4_80_60,
                  mkw(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0006, 8'hAE, 4'h5), "goto_if_z"};
      vecs[5] = '{120'hAE_88_11_7F_5F,
                  mkw(8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0005, 8'hAE, 4'hB), "add_carry_to_d"};
      vecs[6] = '{120'hAE_86_70,
                  mkw(8'hE1, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0003, 8'hAE, 4'hB), "rotate_left"};

      // Reset, then hold IDLE with loadMem low.
      repeat (2) tick;
      reset = 1'b0;
      repeat (3) tick;
      chk("idle_word", bus.returned_from_comp, 96'h0);
      chk("idle_complete", {95'b0, bus.loadMemComplete}, 96'h0);

      for (int v = 0; v < 7; v++) begin
         do_reset;
         chk({vecs[v].name, "_reset_word"}, bus.returned_from_comp, 96'h0);
         chk({vecs[v].name, "_reset_complete"}, {95'b0, bus.loadMemComplete}, 96'h0);
         load(vecs[v].img);
         chk({vecs[v].name, "_load_complete"}, {95'b0, bus.loadMemComplete}, {95'b0, 1'b1});
         chk({vecs[v].name, "_load_word"}, bus.returned_from_comp, 96'h0);
         run_to_halt(vecs[v].name);
         chk({vecs[v].name, "_final"}, bus.returned_from_comp, vecs[v].exp);
         // Halted: state frozen and a fresh load request ignored.
         bus.initial_memory = 120'h41;
         bus.loadMem        = 1'b1;
         repeat (3) tick;
         bus.loadMem = 1'b0;
         chk({vecs[v].name, "_frozen"}, bus.returned_from_comp, vecs[v].exp);
         chk({vecs[v].name, "_frozen_complete"}, {95'b0, bus.loadMemComplete}, {95'b0, 1'b1});
      end

      // Endless GOTO 0 loop, then reset mid-run with loadMem also high.
      do_reset;
      load(120'hE0);
      repeat (7) tick;
      chk("loop_running",  bus.returned_from_comp,
          mkw(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0001, 8'hE0, 4'h0));
      bus.loadMem = 1'b1;
      reset       = 1'b1;
      tick;
      chk("midrun_reset_word", bus.returned_from_comp, 96'h0);
      chk("midrun_reset_complete", {95'b0, bus.loadMemComplete}, 96'h0);
      reset       = 1'b0;
      bus.loadMem = 1'b0;
      tick;
      chk("post_reset_idle", bus.returned_from_comp, 96'h0);

      // Bytes past the image run as MOV A,A; PC wraps 255 -> 0.
      do_reset;
      load(120'h41);
      tick;
      chk("wrap_first", bus.returned_from_comp,
          mkw(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0001, 8'h41, 4'h0));
      tick;
      chk("wrap_zero_byte", bus.returned_from_comp,
          mkw(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0002, 8'h00, 4'h0));
      repeat (254) tick;
      chk("wrap_pc_zero", bus.returned_from_comp, 96'h0);
      tick;
      chk("wrap_second_pass", bus.returned_from_comp,
          mkw(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0001, 8'h41, 4'h0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
